// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
// Holds the controller state encoding and the decimal digit limits.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    function automatic logic bcd_bad(input logic [3:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder with carry in/out.
// Binary sum above nine is corrected by adding six, keeping the low nibble.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] bin;
    logic [4:0] adj;

    always_comb begin
        bin = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        adj = bin + {1'b0, BCD_ADJ};
        if (bin > {1'b0, BCD_MAX}) begin
            s  = adj[3:0];
            co = 1'b1;
        end else begin
            s  = bin[3:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit pair per cycle, LSD first.
// Result digits enter the top of the sum register and settle after DIGITS cycles.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                done,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          err_q, err_d;

    logic [3:0]    dig_s;
    logic          dig_co;
    logic [W-1:0]  sum_shift;
    logic          last_dig;

    bcd_digit_add u_dig (
        .a  (opa_q[3:0]),
        .b  (opb_q[3:0]),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co)
    );

    generate
        if (DIGITS == 1) begin : g_one
            assign sum_shift = dig_s;
        end else begin : g_many
            assign sum_shift = {dig_s, sum_q[W-1:4]};
        end
    endgenerate

    assign last_dig = (idx_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_ADD;
            ST_ADD:  if (last_dig) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands shift right so the active digit pair is always in [3:0].
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_ADD: begin
                opa_d   = opa_q >> 4;
                opb_d   = opb_q >> 4;
                carry_d = dig_co;
                idx_d   = idx_q + IW'(1);
                sum_d   = sum_shift;
                err_d   = err_q | bcd_bad(opa_q[3:0])
                                | bcd_bad(opb_q[3:0]);
                if (last_dig) cout_d = dig_co;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_ADD);
        done = (state_q == ST_FIN);
        sum  = sum_q;
        cout = cout_q;
        err  = err_q;
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (4-digit and 1-digit instances).
module tb_bcd_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, cin4;
    logic [15:0] a4, b4;
    logic        busy4, cout4, done4, err4;
    logic [15:0] sum4;
    logic        start1, cin1;
    logic [3:0]  a1, b1;
    logic        busy1, cout1, done1, err1;
    logic [3:0]  sum1;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .sum(sum4), .cout(cout4), .done(done4), .err(err4)
    );

    bcd_serial_adder #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .sum(sum1), .cout(cout1), .done(done1), .err(err1)
    );

    always @(negedge clk) if (done4) done_cnt++;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal reference for valid operands: {cout, sum}.
    function automatic logic [16:0] ref_dec(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic ci);
        int av = 0, bv = 0, t;
        logic [15:0] s;
        for (int i = 3; i >= 0; i--) begin
            av = av * 10 + int'(a[4*i +: 4]);
            bv = bv * 10 + int'(b[4*i +: 4]);
        end
        t = av + bv + int'(ci);
        for (int i = 0; i < 4; i++) begin
            s[4*i +: 4] = 4'((t / (10 ** i)) % 10);
        end
        return {t >= 10000, s};
    endfunction

    // Digit-rule reference, needed when digits exceed nine.
    function automatic logic [16:0] ref_rule(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic ci);
        int c = int'(ci), t;
        logic [15:0] s;
        for (int i = 0; i < 4; i++) begin
            t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
            if (t > 9) begin
                s[4*i +: 4] = 4'((t + 6) % 16);
                c = 1;
            end else begin
                s[4*i +: 4] = 4'(t);
                c = 0;
            end
        end
        return {c[0], s};
    endfunction

    function automatic logic has_bad(input logic [15:0] v);
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Returns at the negedge of the done cycle; lat counts cycles
    // from the start-sampling edge.
    task automatic run4(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input bit hold,
                        output int lat, output int busyn);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = ci; start4 = 1'b1;
        @(negedge clk);
        if (!hold) start4 = 1'b0;
        lat = 1; busyn = 0;
        while (!done4 && lat < 20) begin
            if (busy4) busyn++;
            @(negedge clk);
            lat++;
        end
        start4 = 1'b0;
        check("done_seen", 64'(done4), 64'(1));
    endtask

    initial begin
        int lat, busyn, dc0;
        logic [15:0] ra, rb;
        logic rc;
        logic [16:0] exp;

        rst = 1'b1; start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy4), 0);
        check("rst_done", 64'(done4), 0);
        check("rst_sum",  64'(sum4), 0);
        check("rst_cout", 64'(cout4), 0);
        check("rst_err",  64'(err4), 0);
        rst = 1'b0;

        run4(16'h1234, 16'h5678, 1'b0, 1'b0, lat, busyn);
        check("ex1_busy_cycles", 64'(busyn), 64'(4));
        check("ex1_latency", 64'(lat), 64'(5));
        check("ex1_sum", 64'(sum4), 64'h6912);
        check("ex1_cout", 64'(cout4), 0);
        check("ex1_err", 64'(err4), 0);
        @(negedge clk);
        check("ex1_done_pulse", 64'(done4), 0);
        check("ex1_sum_hold", 64'(sum4), 64'h6912);

        run4(16'h9999, 16'h0001, 1'b0, 1'b0, lat, busyn);
        check("ex2_sum", 64'(sum4), 0);
        check("ex2_cout", 64'(cout4), 1);
        run4(16'h0000, 16'h0000, 1'b1, 1'b0, lat, busyn);
        check("ex3_sum", 64'(sum4), 1);
        check("ex3_cout", 64'(cout4), 0);

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 4; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(9));
                rb[4*i +: 4] = 4'($urandom_range(9));
            end
            rc = 1'($urandom_range(1));
            exp = ref_dec(ra, rb, rc);
            run4(ra, rb, rc, 1'b0, lat, busyn);
            check("rnd_result", 64'({cout4, sum4}), 64'(exp));
            check("rnd_err", 64'(err4), 0);
        end

        run4(16'h00A0, 16'h0000, 1'b0, 1'b0, lat, busyn);
        check("err_set", 64'(err4), 1);
        check("err_sum", 64'({cout4, sum4}),
              64'(ref_rule(16'h00A0, 16'h0000, 1'b0)));
        run4(16'h0011, 16'h0022, 1'b0, 1'b0, lat, busyn);
        check("err_clear", 64'(err4), 0);
        check("err_clear_sum", 64'(sum4), 64'h0033);

        for (int n = 0; n < 8; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(1));
            exp = ref_rule(ra, rb, rc);
            run4(ra, rb, rc, 1'b0, lat, busyn);
            check("rnd_any_result", 64'({cout4, sum4}), 64'(exp));
            check("rnd_any_err", 64'(err4), 64'(has_bad(ra) | has_bad(rb)));
        end

        run4(16'h9999, 16'h0001, 1'b0, 1'b0, lat, busyn);
        @(negedge clk);
        a4 = 16'h1234; b4 = 16'h5678; cin4 = 0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        dc0 = done_cnt;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy4), 0);
        check("midrst_done", 64'(done4), 0);
        check("midrst_sum", 64'(sum4), 0);
        check("midrst_cout", 64'(cout4), 0);
        check("midrst_err", 64'(err4), 0);
        start4 = 1'b1;
        @(negedge clk);
        check("rst_over_start", 64'(busy4), 0);
        rst = 1'b0; start4 = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt - dc0), 0);

        dc0 = done_cnt;
        run4(16'h4321, 16'h1111, 1'b1, 1'b1, lat, busyn);
        check("hold_sum", 64'(sum4), 64'h5433);
        check("hold_latency", 64'(lat), 64'(5));
        repeat (8) @(negedge clk);
        check("hold_one_done", 64'(done_cnt - dc0), 1);

        for (int ai = 0; ai < 10; ai++) begin
            for (int bi = 0; bi < 10; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    int k, t;
                    @(negedge clk);
                    a1 = 4'(ai); b1 = 4'(bi); cin1 = 1'(ci); start1 = 1'b1;
                    @(negedge clk);
                    start1 = 1'b0;
                    k = 0;
                    while (!done1 && k < 10) begin
                        @(negedge clk);
                        k++;
                    end
                    t = ai + bi + ci;
                    check("sweep", 64'({done1, cout1, sum1}),
                          64'({1'b1, t >= 10, 4'(t % 10)}));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits per operand (legal range 1..8).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 SHALL have port b  input  4*DIGITS  operand B, packed BCD, same packing as a.
REQ-007 SHALL have port cin  input  1  carry into digit 0.
REQ-008 SHALL have port busy  output  1  high while the block is in ADD.
REQ-009 SHALL have port sum  output  4*DIGITS  packed BCD result.
REQ-010 SHALL have port cout  output  1  decimal carry out of the most-significant digit.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking sum/cout/err valid.
REQ-012 SHALL have port err  output  1  high when any latched operand digit exceeded 9.

Function
REQ-013 SHALL implement FSM states IDLE, ADD and FIN; reset state is IDLE.
REQ-014 In IDLE with start=1, SHALL latch a, b and cin, clear the digit index to 0, clear the result shift register, and move to ADD on the same edge.
REQ-015 In ADD, SHALL add exactly one digit pair per cycle, least-significant first, through the digit-adder sub-module, using the carry register as carry-in.
REQ-016 Digit adder: binary s = a_i + b_i + c; if s > 9 then digit = (s + 6) mod 16 and carry = 1, else digit = s and carry = 0.
REQ-017 SHALL shift each result digit into sum from the top so that sum is correctly packed after DIGITS cycles; sum SHALL NOT change while in ADD except by this shift.
REQ-018 SHALL move ADD to FIN after the digit with index DIGITS-1 is processed; FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-019 Latency SHALL be DIGITS+1 cycles from the start-sampling edge to the done-asserted cycle.
REQ-020 sum, cout and err SHALL hold their values from FIN until the next accepted start.
REQ-021 start asserted in ADD or FIN SHALL be ignored, with no queuing.
REQ-022 err SHALL be set when any latched digit of a or b is 10..15; the computation SHALL still complete using REQ-016, and err SHALL clear on the next accepted start.
REQ-023 cout SHALL equal the carry produced by the last digit (for example 9999+0001 gives sum 0000 and cout 1).
REQ-024 busy SHALL be 1 exactly in ADD.

Reset
REQ-025 rst=1 at a clock edge SHALL force state IDLE, busy 0, done 0, sum 0, cout 0, err 0, carry 0 and digit index 0, regardless of state, including mid-ADD.
REQ-026 rst SHALL take priority over start on the same edge.

Structure
REQ-027 State encodings and the constant BCD_MAX = 9 SHALL reside in the shared package bcd_pkg.
REQ-028 SHALL instantiate one combinational sub-module bcd_digit_add (inputs a 4, b 4, ci 1; outputs s 4, co 1) implementing REQ-016.
REQ-029 The digit index counter SHALL be $clog2(DIGITS+1) bits wide.

Verification
REQ-030 With a=0x1234, b=0x5678, cin=0 and a start pulse, the bench SHALL observe busy for 4 cycles, then done with sum=0x6912, cout=0, err=0.
REQ-031 With a=0x9999, b=0x0001, cin=0, the bench SHALL observe sum=0x0000 and cout=1; with a=0x0000, b=0x0000, cin=1, it SHALL observe sum=0x0001 and cout=0.
REQ-032 An exhaustive single-digit sweep (DIGITS=1, a 0..9, b 0..9, cin 0/1) SHALL match decimal a+b+cin for every case.
REQ-033 With a=0x00A0, b=0x0000, the bench SHALL observe err=1 at done; a following valid start SHALL clear err.
REQ-034 Asserting rst at the second ADD cycle of 0x1234+0x5678 SHALL produce no done pulse and all outputs 0 on the next cycle; start held high through ADD SHALL produce exactly one done pulse.
